// File: rtl/fetch_pkg.sv
// Shared widths, constants and the F/D pipeline register layout for the fetch stage.
package fetch_pkg;

   localparam int unsigned XLEN        = 32;
   localparam int unsigned INSTR_BYTES = 4;

   localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'hBFC0_0000;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_plus4;
      logic            valid;
   } fd_reg_t;

   function automatic logic [XLEN-1:0] next_seq_pc(input logic [XLEN-1:0] pc);
      return pc + XLEN'(INSTR_BYTES);
   endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter: redirect beats hold beats sequential increment.
// Redirect targets are forced word-aligned; misalign reports a dropped low bit.
module pc_reg
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            redirect,
   input  logic [XLEN-1:0] target,
   input  logic            hold,
   output logic [XLEN-1:0] pc,
   output logic            misalign
);

   assign misalign = redirect & (target[1:0] != 2'b00);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc <= RESET_PC;
      end else if (redirect) begin
         pc <= {target[XLEN-1:2], 2'b00};
      end else if (!hold) begin
         pc <= next_seq_pc(pc);
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Pipeline front end: owns the PC, addresses the ROM and fills the F/D register.
// Also keeps a sticky misaligned-redirect flag and a count of valid F/D loads.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic [XLEN-1:0] F_addr,
   input  logic [XLEN-1:0] F_instr,
   input  logic            stall_F,
   input  logic            stall_D,
   input  logic            flush_D,
   input  logic            redirect_E,
   input  logic [XLEN-1:0] E_target,
   output logic [XLEN-1:0] D_instr,
   output logic [XLEN-1:0] D_pc,
   output logic [XLEN-1:0] D_pc_plus4,
   output logic            D_valid,
   output logic            misalign_err,
   output logic [XLEN-1:0] fetch_count
);

   logic [XLEN-1:0] pc_F;
   logic            hold_F;
   logic            target_misaligned;
   fd_reg_t         fd_q;

   // A held F/D register must also hold the PC or the instruction in F is lost.
   assign hold_F = stall_F | stall_D;

   pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk      (clk),
      .rst_n    (rst_n),
      .redirect (redirect_E),
      .target   (E_target),
      .hold     (hold_F),
      .pc       (pc_F),
      .misalign (target_misaligned)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fd_q.instr    <= NOP_INSTR;
         fd_q.pc       <= '0;
         fd_q.pc_plus4 <= '0;
         fd_q.valid    <= 1'b0;
         misalign_err  <= 1'b0;
         fetch_count   <= '0;
      end else begin
         if (target_misaligned) begin
            misalign_err <= 1'b1;
         end
         // The squashed slot still records its PC so a bubble can be traced.
         if (flush_D || redirect_E) begin
            fd_q.instr    <= NOP_INSTR;
            fd_q.pc       <= pc_F;
            fd_q.pc_plus4 <= next_seq_pc(pc_F);
            fd_q.valid    <= 1'b0;
         end else if (!stall_D) begin
            fd_q.instr    <= F_instr;
            fd_q.pc       <= pc_F;
            fd_q.pc_plus4 <= next_seq_pc(pc_F);
            fd_q.valid    <= 1'b1;
            fetch_count   <= fetch_count + 1'b1;
         end
      end
   end

   assign F_addr     = pc_F;
   assign D_instr    = fd_q.instr;
   assign D_pc       = fd_q.pc;
   assign D_pc_plus4 = fd_q.pc_plus4;
   assign D_valid    = fd_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a combinational ROM model and an expected-instruction queue.
module tb_fetch_stage;

   localparam logic [31:0] RST_PC = 32'hBFC0_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   logic [31:0] F_addr;
   logic [31:0] F_instr;
   logic        stall_F;
   logic        stall_D;
   logic        flush_D;
   logic        redirect_E;
   logic [31:0] E_target;
   logic [31:0] D_instr;
   logic [31:0] D_pc;
   logic [31:0] D_pc_plus4;
   logic        D_valid;
   logic        misalign_err;
   logic [31:0] fetch_count;

   int total;
   int bad;
   logic [31:0] exp_q[$];

   fetch_stage dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .F_addr       (F_addr),
      .F_instr      (F_instr),
      .stall_F      (stall_F),
      .stall_D      (stall_D),
      .flush_D      (flush_D),
      .redirect_E   (redirect_E),
      .E_target     (E_target),
      .D_instr      (D_instr),
      .D_pc         (D_pc),
      .D_pc_plus4   (D_pc_plus4),
      .D_valid      (D_valid),
      .misalign_err (misalign_err),
      .fetch_count  (fetch_count)
   );

   // Clock and ROM model
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] rom(input logic [31:0] addr);
      case (addr)
         RST_PC:           return 32'h1111_1111;
         RST_PC + 32'd4:   return 32'h2222_2222;
         RST_PC + 32'd8:   return 32'h3333_3333;
         default:          return ~addr;
      endcase
   endfunction

   assign F_instr = rom(F_addr);

   // Checking
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   task automatic check_load(input string tag);
      logic [31:0] e;
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s: expected queue empty, got=%08h", tag, D_instr);
      end else begin
         e = exp_q.pop_front();
         check(tag, D_instr, e);
      end
   endtask

   // Driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic sf, input logic sd, input logic fl,
                        input logic rd, input logic [31:0] tgt);
      stall_F    = sf;
      stall_D    = sd;
      flush_D    = fl;
      redirect_E = rd;
      E_target   = tgt;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_faddr"}, F_addr, RST_PC);
      check({tag, "_dinstr"}, D_instr, NOP);
      check({tag, "_dpc"}, D_pc, 32'h0);
      check({tag, "_dpc4"}, D_pc_plus4, 32'h0);
      check({tag, "_dvalid"}, {31'b0, D_valid}, 32'h0);
      check({tag, "_misalign"}, {31'b0, misalign_err}, 32'h0);
      check({tag, "_count"}, fetch_count, 32'h0);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      step();
      step();
      check_reset_state("rst");
      rst_n = 1'b1;

      // Free run: two loads, PC sits at BFC00008
      exp_q.push_back(32'h1111_1111);
      exp_q.push_back(32'h2222_2222);
      step();
      check("run1_faddr", F_addr, 32'hBFC0_0004);
      check_load("run1_instr");
      check("run1_dpc", D_pc, 32'hBFC0_0000);
      check("run1_dpc4", D_pc_plus4, 32'hBFC0_0004);
      check("run1_valid", {31'b0, D_valid}, 32'h1);
      step();
      check("run2_faddr", F_addr, 32'hBFC0_0008);
      check_load("run2_instr");
      check("run2_count", fetch_count, 32'd2);

      // Full stall for two cycles
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 2; i++) begin
         step();
         check("stall_faddr", F_addr, 32'hBFC0_0008);
         check("stall_instr", D_instr, 32'h2222_2222);
         check("stall_dpc", D_pc, 32'hBFC0_0004);
         check("stall_count", fetch_count, 32'd2);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      exp_q.push_back(32'h3333_3333);
      step();
      check_load("resume_instr");
      check("resume_faddr", F_addr, 32'hBFC0_000C);
      check("resume_count", fetch_count, 32'd3);

      // Redirect while stall_F is high
      drive(1'b1, 1'b0, 1'b0, 1'b1, 32'hBFC0_0040);
      step();
      check("redir_faddr", F_addr, 32'hBFC0_0040);
      check("redir_instr", D_instr, NOP);
      check("redir_valid", {31'b0, D_valid}, 32'h0);
      check("redir_count", fetch_count, 32'd3);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      exp_q.push_back(rom(32'hBFC0_0040));
      step();
      check("redir2_dpc", D_pc, 32'hBFC0_0040);
      check_load("redir2_instr");
      check("redir2_count", fetch_count, 32'd4);

      // Misaligned redirect: truncated target, sticky flag
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hBFC0_0046);
      step();
      check("mis_faddr", F_addr, 32'hBFC0_0044);
      check("mis_flag", {31'b0, misalign_err}, 32'h1);
      check("mis_valid", {31'b0, D_valid}, 32'h0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 10; i++) begin
         step();
         check("mis_sticky", {31'b0, misalign_err}, 32'h1);
      end
      check("mis_run_faddr", F_addr, 32'hBFC0_006C);
      check("mis_run_count", fetch_count, 32'd14);

      // Flush and stall_D together: flush wins, no count
      drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      step();
      check("flush_instr", D_instr, NOP);
      check("flush_valid", {31'b0, D_valid}, 32'h0);
      check("flush_count", fetch_count, 32'd14);
      check("flush_faddr", F_addr, 32'hBFC0_006C);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      exp_q.push_back(rom(32'hBFC0_006C));
      step();
      check_load("post_flush_instr");
      check("post_flush_count", fetch_count, 32'd15);

      // PC wrap at the top of the address space
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
      step();
      check("wrap_faddr0", F_addr, 32'hFFFF_FFFC);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      exp_q.push_back(rom(32'hFFFF_FFFC));
      step();
      check("wrap_faddr1", F_addr, 32'h0000_0000);
      check_load("wrap_instr");
      check("wrap_dpc", D_pc, 32'hFFFF_FFFC);
      check("wrap_dpc4", D_pc_plus4, 32'h0000_0000);
      check("wrap_count", fetch_count, 32'd16);

      // Reset mid-stream overrides a pending redirect and stall
      rst_n = 1'b0;
      drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0101);
      step();
      check_reset_state("rst2");
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      exp_q.push_back(32'h1111_1111);
      step();
      check("rst2_run_faddr", F_addr, 32'hBFC0_0004);
      check_load("rst2_run_instr");
      check("rst2_run_count", fetch_count, 32'd1);

      check("queue_drained", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
